ref_level_tracker: RTL and testbench

Parametrised successor to the 16QAM slicer reference-level generator. Tracks average |decision variable| over a programmable window of 2^log2_window symbols, independently for NUM_CH channels (default 2: I and Q). Runs on the system clock with sym_clk_ena as a qualifier instead of an edge. At each window end it publishes reference level, mapper output power (1.25*ref^2) and a one-cycle valid strobe to the slicer and the MER/gain-control logic.

---
 rtl/qam_ref_pkg.sv | 50 +++++
 rtl/ref_level_chan.sv | 111 +++++++++++
 rtl/ref_level_tracker.sv | 154 +++++++++++++++
 tb/tb_ref_level_tracker.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qam_ref_pkg.sv
// Shared types, constants and arithmetic helpers for the slicer reference-level tracker.
// The helpers are sized for the default decision-variable width DW_DEF.
package qam_ref_pkg;

    localparam int DW_DEF           = 18;
    localparam int MAX_LOG2_WIN_DEF = 20;
    localparam int PW_DEF           = 2 * DW_DEF + 3;
    localparam int EMA_SHIFT        = 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCUM  = 3'd1,
        SCALE  = 3'd2,
        POWER  = 3'd3,
        UPDATE = 3'd4
    } state_t;

    // |x| with the most-negative code mapped to the largest positive code.
    function automatic logic [DW_DEF-1:0] sat_abs(input logic signed [DW_DEF-1:0] x);
        logic [DW_DEF-1:0] r;
        if (x == {1'b1, {(DW_DEF-1){1'b0}}}) begin
            r = {1'b0, {(DW_DEF-1){1'b1}}};
        end else if (x[DW_DEF-1]) begin
            r = -x;
        end else begin
            r = x;
        end
        return r;
    endfunction

    // 1.25 * lvl^2 evaluated as sq + sq/4.
    function automatic logic signed [PW_DEF-1:0] power_1p25(input logic signed [DW_DEF-1:0] lvl);
        logic signed [2*DW_DEF-1:0] sq;
        sq = (2*DW_DEF)'(lvl) * (2*DW_DEF)'(lvl);
        return PW_DEF'(sq) + PW_DEF'(sq >>> 2);
    endfunction

    function automatic logic [4:0] clamp_win(input logic [4:0] w, input logic [4:0] max_w);
        logic [4:0] r;
        if (w == 5'd0) begin
            r = 5'd1;
        end else if (w > max_w) begin
            r = max_w;
        end else begin
            r = w;
        end
        return r;
    endfunction

endpackage

// File: rtl/ref_level_chan.sv
// Per-channel datapath: |x| accumulation, window scaling, power and output registers.
// Optional smoothing of the published level is enabled by REF_LEVEL_EMA_EN.
module ref_level_chan
    import qam_ref_pkg::*;
#(
    parameter int DW           = DW_DEF,
    parameter int MAX_LOG2_WIN = MAX_LOG2_WIN_DEF,
    parameter int PW           = PW_DEF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 acc_clr,
    input  logic                 acc_add,
    input  logic                 scale_en,
    input  logic                 power_en,
    input  logic                 update_en,
`ifdef REF_LEVEL_EMA_EN
    input  logic                 publish_en,
    input  logic                 first_win,
`endif
    input  logic [4:0]           win_exp,
    input  logic signed [DW-1:0] x,
    output logic signed [DW-1:0] ref_level,
    output logic signed [PW-1:0] power
);

    localparam int AW = DW + MAX_LOG2_WIN;

    logic [AW-1:0]        acc_r;
    logic [AW-1:0]        shifted_s;
    logic signed [DW-1:0] lvl_s;
    logic signed [DW-1:0] lvl_r;
    logic signed [PW-1:0] pwr_r;
    logic signed [DW-1:0] ref_r;
    logic signed [PW-1:0] power_r;

    // Window average, clipped to the largest positive level.
    always_comb begin
        shifted_s = acc_r >> win_exp;
        if (|shifted_s[AW-1:DW-1]) begin
            lvl_s = {1'b0, {(DW-1){1'b1}}};
        end else begin
            lvl_s = shifted_s[DW-1:0];
        end
    end

    // Accumulate, scale and square stages.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_r <= {AW{1'b0}};
            lvl_r <= {DW{1'b0}};
            pwr_r <= {PW{1'b0}};
        end else begin
            if (acc_clr) begin
                acc_r <= {AW{1'b0}};
            end else if (acc_add) begin
                acc_r <= acc_r + AW'(sat_abs(x));
            end
            if (scale_en) begin
                lvl_r <= lvl_s;
            end
            if (power_en) begin
                pwr_r <= PW'(power_1p25(lvl_r));
            end
        end
    end

`ifdef REF_LEVEL_EMA_EN
    logic signed [DW-1:0] ema_r;
    logic signed [DW:0]   diff_s;
    logic signed [DW-1:0] ema_s;

    // ema + (lvl - ema)/8 with one guard bit so the difference cannot wrap.
    always_comb begin
        diff_s = (DW+1)'(lvl_r) - (DW+1)'(ema_r);
        ema_s  = DW'((DW+1)'(ema_r) + (diff_s >>> EMA_SHIFT));
    end

    // Smoothed level is settled first, then published together with its power.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ema_r   <= {DW{1'b0}};
            ref_r   <= {DW{1'b0}};
            power_r <= {PW{1'b0}};
        end else begin
            if (update_en) begin
                ema_r <= first_win ? lvl_r : ema_s;
            end
            if (publish_en) begin
                ref_r   <= ema_r;
                power_r <= PW'(power_1p25(ema_r));
            end
        end
    end
`else
    // Publish the latest window's level and power.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ref_r   <= {DW{1'b0}};
            power_r <= {PW{1'b0}};
        end else if (update_en) begin
            ref_r   <= lvl_r;
            power_r <= pwr_r;
        end
    end
`endif

    assign ref_level = ref_r;
    assign power     = power_r;

endmodule

// File: rtl/ref_level_tracker.sv
// Windowed average |decision variable| tracker: FSM, symbol counter and NUM_CH channel datapaths.
// Define REF_LEVEL_EMA_EN to smooth the published level (adds one cycle of latency).
module ref_level_tracker
    import qam_ref_pkg::*;
#(
    parameter int DW           = DW_DEF,
    parameter int NUM_CH       = 2,
    parameter int MAX_LOG2_WIN = MAX_LOG2_WIN_DEF,
    parameter int PW           = 2 * DW + 3
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        sym_clk_ena,
    input  logic signed [NUM_CH*DW-1:0] decision_variable,
    input  logic [4:0]                  log2_window,
    input  logic                        restart,
    output logic signed [NUM_CH*DW-1:0] reference_level,
    output logic signed [NUM_CH*PW-1:0] mapper_out_power,
    output logic                        ref_valid,
    output logic                        busy
);

    state_t                  state_r;
    logic [MAX_LOG2_WIN-1:0] cnt_r;
    logic [MAX_LOG2_WIN-1:0] last_cnt_s;
    logic [4:0]              win_exp_r;
    logic [4:0]              win_new_s;
    logic                    last_s;
    logic                    acc_add_s;
    logic                    acc_clr_s;
    logic                    update_s;
    logic                    ref_valid_r;
    logic                    busy_r;

    // Window bookkeeping and stage enables; restart overrides everything.
    always_comb begin
        win_new_s  = clamp_win(log2_window, 5'(MAX_LOG2_WIN));
        last_cnt_s = (MAX_LOG2_WIN'(1) << win_exp_r) - MAX_LOG2_WIN'(1);
        last_s     = (cnt_r == last_cnt_s);
        acc_add_s  = (state_r == ACCUM) && sym_clk_ena && !restart;
        acc_clr_s  = restart || (state_r == UPDATE);
        update_s   = (state_r == UPDATE) && !restart;
    end

    // Control FSM with symbol counter and busy flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= IDLE;
            cnt_r     <= {MAX_LOG2_WIN{1'b0}};
            win_exp_r <= 5'd0;
            busy_r    <= 1'b0;
        end else if (restart) begin
            state_r   <= ACCUM;
            cnt_r     <= {MAX_LOG2_WIN{1'b0}};
            win_exp_r <= win_new_s;
            busy_r    <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    state_r   <= ACCUM;
                    cnt_r     <= {MAX_LOG2_WIN{1'b0}};
                    win_exp_r <= win_new_s;
                    busy_r    <= 1'b1;
                end
                ACCUM: begin
                    if (sym_clk_ena) begin
                        if (last_s) begin
                            state_r <= SCALE;
                            cnt_r   <= {MAX_LOG2_WIN{1'b0}};
                            busy_r  <= 1'b0;
                        end else begin
                            cnt_r <= cnt_r + MAX_LOG2_WIN'(1);
                        end
                    end
                end
                SCALE: begin
                    state_r <= POWER;
                end
                POWER: begin
                    state_r <= UPDATE;
                end
                UPDATE: begin
                    state_r   <= ACCUM;
                    cnt_r     <= {MAX_LOG2_WIN{1'b0}};
                    win_exp_r <= win_new_s;
                    busy_r    <= 1'b1;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

`ifdef REF_LEVEL_EMA_EN
    logic pend_r;
    logic first_r;

    // Publication trails the smoothing update by one cycle; first window loads directly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_r      <= 1'b0;
            first_r     <= 1'b1;
            ref_valid_r <= 1'b0;
        end else begin
            pend_r      <= update_s;
            ref_valid_r <= pend_r;
            if (restart) begin
                first_r <= 1'b1;
            end else if (update_s) begin
                first_r <= 1'b0;
            end
        end
    end
`else
    // Valid strobe coincides with the output register update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ref_valid_r <= 1'b0;
        end else begin
            ref_valid_r <= update_s;
        end
    end
`endif

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        ref_level_chan #(
            .DW           (DW),
            .MAX_LOG2_WIN (MAX_LOG2_WIN),
            .PW           (PW)
        ) u_chan (
            .clk       (clk),
            .reset_n   (reset_n),
            .acc_clr   (acc_clr_s),
            .acc_add   (acc_add_s),
            .scale_en  (state_r == SCALE),
            .power_en  (state_r == POWER),
            .update_en (update_s),
`ifdef REF_LEVEL_EMA_EN
            .publish_en(pend_r),
            .first_win (first_r),
`endif
            .win_exp   (win_exp_r),
            .x         (decision_variable[c*DW +: DW]),
            .ref_level (reference_level[c*DW +: DW]),
            .power     (mapper_out_power[c*PW +: PW])
        );
    end

    assign ref_valid = ref_valid_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_ref_level_tracker.sv
// Scoreboard bench for ref_level_tracker: a window-level reference model predicts each
// publication (levels, powers, arrival cycle); a monitor compares on every ref_valid.
module tb_ref_level_tracker;

    localparam int DW  = 18;
    localparam int NCH = 2;
    localparam int PW  = 2 * DW + 3;
`ifdef REF_LEVEL_EMA_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 sym_clk_ena = 1'b0;
    logic                 restart = 1'b0;
    logic [NCH*DW-1:0]    decision_variable = '0;
    logic [4:0]           log2_window = 5'd2;
    logic [NCH*DW-1:0]    reference_level;
    logic [NCH*PW-1:0]    mapper_out_power;
    logic                 ref_valid;
    logic                 busy;

    ref_level_tracker dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .sym_clk_ena       (sym_clk_ena),
        .decision_variable (decision_variable),
        .log2_window       (log2_window),
        .restart           (restart),
        .reference_level   (reference_level),
        .mapper_out_power  (mapper_out_power),
        .ref_valid         (ref_valid),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        longint r0, r1, p0, p1;
        int     cyc;
    } exp_t;
    exp_t sb[$];

    // Reference model: window contents as sums, plus pending-publication countdown.
    bit     m_idle = 1'b1;
    bit     m_first = 1'b1;
    int     m_win = 1;
    int     m_n = 0;
    int     m_post = 0;
    longint m_sum[NCH];
    longint m_lvl[NCH];
    longint m_ema[NCH];
    int     cur_lw = 2;

    task automatic check(string name, longint act, longint expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic longint get_ref(int c);
        return longint'($signed(reference_level[c*DW +: DW]));
    endfunction

    function automatic longint get_pwr(int c);
        return longint'($signed(mapper_out_power[c*PW +: PW]));
    endfunction

    function automatic longint sabs(longint x);
        if (x == -131072) return 131071;
        return (x < 0) ? -x : x;
    endfunction

    function automatic int clampw(int w);
        if (w == 0) return 1;
        if (w > 20) return 20;
        return w;
    endfunction

    task automatic model_clear_window(int lw);
        m_win = clampw(lw);
        m_n   = 0;
        for (int c = 0; c < NCH; c++) m_sum[c] = 0;
    endtask

    task automatic model_publish();
        exp_t   e;
        longint r[NCH];
        for (int c = 0; c < NCH; c++) begin
`ifdef REF_LEVEL_EMA_EN
            r[c] = m_first ? m_lvl[c] : m_ema[c] + ((m_lvl[c] - m_ema[c]) >>> 3);
            m_ema[c] = r[c];
`else
            r[c] = m_lvl[c];
`endif
        end
        m_first = 1'b0;
        e.r0  = r[0];
        e.r1  = r[1];
        e.p0  = (5 * r[0] * r[0]) / 4;
        e.p1  = (5 * r[1] * r[1]) / 4;
        e.cyc = cyc + LAT - 3;
        sb.push_back(e);
    endtask

    task automatic model_edge(bit s, longint x0, longint x1, bit rs, int lw);
        if (m_idle) begin
            m_idle = 1'b0;
            m_post = 0;
            model_clear_window(lw);
        end else if (rs) begin
            m_post  = 0;
            m_first = 1'b1;
            model_clear_window(lw);
        end else if (m_post > 0) begin
            m_post--;
            if (m_post == 0) begin
                model_publish();
                model_clear_window(lw);
            end
        end else if (s) begin
            m_sum[0] += sabs(x0);
            m_sum[1] += sabs(x1);
            m_n++;
            if (m_n == (1 << m_win)) begin
                for (int c = 0; c < NCH; c++) begin
                    m_lvl[c] = m_sum[c] >>> m_win;
                    if (m_lvl[c] > 131071) m_lvl[c] = 131071;
                end
                m_post = 3;
            end
        end
    endtask

    // One clock: drive inputs, let the edge happen, advance the model.
    task automatic step(bit s, longint x0, longint x1, bit rs);
        sym_clk_ena       = s;
        decision_variable = {DW'(x1), DW'(x0)};
        restart           = rs;
        log2_window       = 5'(cur_lw);
        @(posedge clk);
        #1;
        model_edge(s, x0, x1, rs, cur_lw);
        sym_clk_ena = 1'b0;
        restart     = 1'b0;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0);
    endtask

    task automatic sym(longint x0, longint x1);
        step(1'b1, x0, x1, 1'b0);
        idle(3);
    endtask

    task automatic chk_zero(string tag);
        check({tag, "_ref0"}, get_ref(0), 0);
        check({tag, "_ref1"}, get_ref(1), 0);
        check({tag, "_pwr0"}, get_pwr(0), 0);
        check({tag, "_pwr1"}, get_pwr(1), 0);
        check({tag, "_valid"}, longint'(ref_valid), 0);
        check({tag, "_busy"}, longint'(busy), 0);
    endtask

    // Asynchronous reset asserted between clock edges.
    task automatic do_reset();
        #2;
        reset_n = 1'b0;
        sb.delete();
        m_idle  = 1'b1;
        m_first = 1'b1;
        m_post  = 0;
        #1;
        chk_zero("async_reset");
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // Monitor: every ref_valid must match the oldest predicted publication.
    always @(negedge clk) begin
        if (reset_n && ref_valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_valid: got ref_valid=1 at cycle %0d, expected none", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("ref0", get_ref(0), e.r0);
                check("ref1", get_ref(1), e.r1);
                check("pwr0", get_pwr(0), e.p0);
                check("pwr1", get_pwr(1), e.p1);
                check("valid_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        for (int c = 0; c < NCH; c++) begin
            m_sum[c] = 0;
            m_lvl[c] = 0;
            m_ema[c] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        reset_n = 1'b1;

        // Basic window: alternating-sign ch0, constant ch1.
        cur_lw = 2;
        idle(2);
        sym(100, 40);
        check("busy_in_window", longint'(busy), 1);
        sym(-100, 40);
        sym(100, 40);
        sym(-100, 40);
        idle(2);
        check("t1_ref0", get_ref(0), 100);
        check("t1_ref1", get_ref(1), 40);
        check("t1_pwr0", get_pwr(0), 12500);
        check("t1_pwr1", get_pwr(1), 2000);

        // Most-negative input must saturate, not wrap.
        for (int i = 0; i < 4; i++) sym(-131072, 40);
        idle(2);
`ifndef REF_LEVEL_EMA_EN
        check("t2_ref0_sat", get_ref(0), 131071);
`endif

        // Restart on the window-final symbol: no publication, outputs hold.
        for (int i = 0; i < 3; i++) sym(500, 500);
        step(1'b1, 500, 500, 1'b1);
        idle(6);
`ifndef REF_LEVEL_EMA_EN
        check("t3_hold_ref0", get_ref(0), 131071);
        check("t3_hold_ref1", get_ref(1), 40);
`endif
        sym(8, -8);
        sym(16, -16);
        sym(24, -24);
        sym(32, -32);
        idle(2);

        // Window exponent changed mid-window: applies from the next window.
        sym(1000, 7);
        sym(2000, 7);
        cur_lw = 3;
        sym(3000, 7);
        sym(4000, 7);
        for (int i = 0; i < 8; i++) sym(i * 1000, -i * 3);
        idle(2);

        // Async reset mid-window, then a full fresh window.
        cur_lw = 2;
        sym(5000, 5000);
        sym(5000, 5000);
        do_reset();
        idle(1);
        for (int i = 0; i < 4; i++) sym(200 * (i + 1), -300);
        idle(2);

`ifdef REF_LEVEL_EMA_EN
        do_reset();
        idle(1);
        for (int i = 0; i < 4; i++) sym(800, -800);
        for (int i = 0; i < 4; i++) sym(0, 0);
        idle(3);
        check("ema_ref0", get_ref(0), 700);
        check("ema_ref1", get_ref(1), 700);
`endif

        // Randomized traffic: data, gaps, exponent changes, restarts.
        for (int i = 0; i < 300; i++) begin
            longint x0, x1;
            if ($urandom_range(0, 19) == 0) cur_lw = $urandom_range(0, 4);
            x0 = ($urandom_range(0, 9) == 0) ? -131072 : longint'($signed(DW'($urandom)));
            x1 = ($urandom_range(0, 9) == 0) ? -131072 : longint'($signed(DW'($urandom)));
            step(1'b1, x0, x1, $urandom_range(0, 39) == 0);
            idle($urandom_range(3, 5));
        end

        // Drain pending publications within a bounded time.
        for (int i = 0; i < 50 && sb.size() != 0; i++) idle(1);
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d pending publications, expected 0", sb.size());
        end
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
